// File: rtl/if_id_queue_pkg.sv
// Shared IF/ID definitions: datapath width, NOP encoding and reset PC,
// so fetch, the queue and decode all agree on one set of constants.
package if_id_queue_pkg;

  // Width of the instruction word and of the pc8 field.
  localparam int DATA_W = 32;

  // All-zero word (sll $0,$0,0) presented to decode when the queue is empty.
  localparam logic [DATA_W-1:0] NOP_INSTR = 32'h0000_0000;

  // Address of the first instruction fetched after reset.
  localparam logic [DATA_W-1:0] RESET_PC = 32'h0000_3000;

  // Decode gets pc8 (PC+8) from the queue; this recovers the instruction PC.
  function automatic logic [DATA_W-1:0] pc_from_pc8(input logic [DATA_W-1:0] pc8);
    return pc8 - DATA_W'(8);
  endfunction

endpackage

// File: rtl/if_id_queue.sv
// IF/ID instruction queue: a small circular FIFO of {instr, pc8} pairs.
// Fetch stalls only when the queue is full; decode sees the oldest pair
// combinationally (masked to NOP/0 when empty); flush drops everything.
module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DW    = DATA_W
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic                   flush,
  input  logic                   in_valid,
  input  logic [DW-1:0]          in_instr,
  input  logic [DW-1:0]          in_pc8,
  output logic                   in_ready,
  output logic                   out_valid,
  output logic [DW-1:0]          out_instr,
  output logic [DW-1:0]          out_pc8,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  // Occupancy value meaning "full"; full/empty come from the count, never
  // from pointer equality, so both pointers may be equal in either state.
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // Storage; contents are never reset, only the control state is.
  logic [DW-1:0] instr_mem [DEPTH];
  logic [DW-1:0] pc8_mem   [DEPTH];

  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q,  count_d;

  logic push;
  logic pop;

  // Handshakes: a full queue refuses pushes even when a pop happens in the
  // same cycle, which keeps in_ready independent of out_ready.
  assign in_ready  = (count_q != FULL_CNT);
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign count     = count_q;

  // Head presentation: no bypass from in_*, so a push shows up next cycle.
  assign out_instr = out_valid ? instr_mem[rd_ptr_q] : DW'(NOP_INSTR);
  assign out_pc8   = out_valid ? pc8_mem[rd_ptr_q]   : '0;

  // Next-state for pointers and occupancy; flush overrides push and pop.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Pointers are log2(DEPTH) bits wide, so +1 wraps modulo DEPTH.
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register; clr clears occupancy immediately.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry write; a push coinciding with flush is dropped.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      instr_mem[wr_ptr_q] <= in_instr;
      pc8_mem[wr_ptr_q]   <= in_pc8;
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue: scoreboard queue of expected
// {instr, pc8} pairs, updated at each clock edge from the driven stimulus.
module tb_if_id_queue;

  localparam int DEPTH = 4;
  localparam int DW    = 32;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc8;
  } ent_t;

  logic          clk = 1'b0;
  logic          clr;
  logic          flush;
  logic          in_valid;
  logic [DW-1:0] in_instr;
  logic [DW-1:0] in_pc8;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_instr;
  logic [DW-1:0] out_pc8;
  logic          out_ready;
  logic [2:0]    count;

  ent_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [31:0] fd_instr [4] = '{32'h24080001, 32'h24090002, 32'h240A0003, 32'h240B0004};
  logic [31:0] fd_pc8   [4] = '{32'h00003008, 32'h0000300C, 32'h00003010, 32'h00003014};

  if_id_queue #(.DEPTH(DEPTH), .DW(DW)) dut (
    .clk       (clk),
    .clr       (clr),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_instr  (in_instr),
    .in_pc8    (in_pc8),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_instr (out_instr),
    .out_pc8   (out_pc8),
    .out_ready (out_ready),
    .count     (count)
  );

  always #5 clk = ~clk;

  // Apply one clock edge with the current inputs and update the model.
  task automatic tick();
    int   sz;
    bit   do_push;
    bit   do_pop;
    ent_t e;
    sz      = sb.size();
    do_push = in_valid && (sz < DEPTH);
    do_pop  = out_ready && (sz > 0);
    @(posedge clk);
    if (flush) begin
      sb.delete();
      $display("[%0t] flush", $time);
    end else begin
      if (do_pop) begin
        e = sb.pop_front();
        $display("[%0t] pop  instr=%h pc8=%h", $time, e.instr, e.pc8);
      end
      if (do_push) begin
        e.instr = in_instr;
        e.pc8   = in_pc8;
        sb.push_back(e);
        $display("[%0t] push instr=%h pc8=%h", $time, e.instr, e.pc8);
      end
    end
    #1;
  endtask

  task automatic test_reset();
    #2 clr = 1'b1;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_checks++; if (out_instr !== 32'h0) begin n_fail++; $display("FAIL reset_out_instr: got %h want 0", out_instr); end
    n_checks++; if (out_pc8 !== 32'h0) begin n_fail++; $display("FAIL reset_out_pc8: got %h want 0", out_pc8); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
    @(negedge clk);
    clr = 1'b0;
    sb.delete();
  endtask

  task automatic test_fill_drain();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_instr = fd_instr[i]; in_pc8 = fd_pc8[i];
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL fill_in_ready[%0d]: got %b want 1", i, in_ready); end
      tick();
    end
    n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL fill_count: got %0d want 4", count); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL fill_full_in_ready: got %b want 0", in_ready); end
    in_instr = 32'h240C0005; in_pc8 = 32'h00003018;
    tick();
    n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL fifth_push_count: got %0d want 4", count); end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL drain_valid[%0d]: got %b want 1", i, out_valid); end
      n_checks++; if (out_instr !== fd_instr[i] || out_instr !== sb[0].instr) begin n_fail++; $display("FAIL drain_instr[%0d]: got %h want %h", i, out_instr, fd_instr[i]); end
      n_checks++; if (out_pc8 !== fd_pc8[i]) begin n_fail++; $display("FAIL drain_pc8[%0d]: got %h want %h", i, out_pc8, fd_pc8[i]); end
      tick();
    end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL drained_valid: got %b want 0", out_valid); end
    n_checks++; if (out_instr !== 32'h0) begin n_fail++; $display("FAIL drained_instr: got %h want 0", out_instr); end
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL drained_count: got %0d want 0", count); end
    out_ready = 1'b0;
  endtask

  task automatic test_streaming();
    int emerged;
    emerged = 0;
    out_ready = 1'b1;
    for (int c = 0; c <= 10; c++) begin
      if (c < 10) begin
        in_valid = 1'b1; in_instr = 32'h24100000 + c; in_pc8 = 32'h00003008 + 4 * c;
      end else begin
        in_valid = 1'b0;
      end
      if (c == 0) begin
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_first_valid: got %b want 0", out_valid); end
      end else begin
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid[%0d]: got %b want 1", c, out_valid); end
        n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL stream_count[%0d]: got %0d want 1", c, count); end
        n_checks++; if (out_instr !== 32'h24100000 + emerged) begin n_fail++; $display("FAIL stream_instr[%0d]: got %h want %h", c, out_instr, 32'h24100000 + emerged); end
        n_checks++; if (out_pc8 !== 32'h00003008 + 4 * emerged) begin n_fail++; $display("FAIL stream_pc8[%0d]: got %h want %h", c, out_pc8, 32'h00003008 + 4 * emerged); end
        emerged++;
      end
      tick();
    end
    n_checks++; if (out_valid !== 1'b0 || count !== 3'd0) begin n_fail++; $display("FAIL stream_end_empty: got valid=%b count=%0d want 0/0", out_valid, count); end
    n_checks++; if (emerged != 10) begin n_fail++; $display("FAIL stream_emerged: got %0d want 10", emerged); end
    out_ready = 1'b0;
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_instr = 32'h24200000 + i; in_pc8 = 32'h00003100 + 4 * i;
      tick();
    end
    n_checks++; if (count !== 3'd3) begin n_fail++; $display("FAIL flush_pre_count: got %0d want 3", count); end
    flush = 1'b1; in_valid = 1'b1; in_instr = 32'hDEAD0001; in_pc8 = 32'h0000310C; out_ready = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL flush_count: got %0d want 0", count); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b want 0", out_valid); end
    in_valid = 1'b1; in_instr = 32'h24110011; in_pc8 = 32'h00003040;
    tick();
    in_valid = 1'b0;
    n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL post_flush_count: got %0d want 1", count); end
    n_checks++; if (out_instr !== 32'h24110011 || out_instr !== sb[0].instr) begin n_fail++; $display("FAIL post_flush_instr: got %h want 24110011", out_instr); end
    n_checks++; if (out_pc8 !== 32'h00003040) begin n_fail++; $display("FAIL post_flush_pc8: got %h want 00003040", out_pc8); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL post_flush_alone: got valid=%b want 0", out_valid); end
  endtask

  task automatic test_full_pop();
    logic [31:0] exp_order [4];
    exp_order = '{32'h24300001, 32'h24300002, 32'h24300003, 32'h24300004};
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_instr = 32'h24300000 + i; in_pc8 = 32'h00003200 + 4 * i;
      tick();
    end
    n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL fullpop_pre_count: got %0d want 4", count); end
    in_valid = 1'b1; in_instr = 32'h24300004; in_pc8 = 32'h00003210; out_ready = 1'b1;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL fullpop_in_ready: got %b want 0", in_ready); end
    tick();
    n_checks++; if (count !== 3'd3) begin n_fail++; $display("FAIL fullpop_count: got %0d want 3", count); end
    out_ready = 1'b0;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL fullpop_retry_ready: got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL fullpop_retry_count: got %0d want 4", count); end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (out_valid !== 1'b1 || out_instr !== exp_order[i] || out_instr !== sb[0].instr) begin n_fail++; $display("FAIL fullpop_order[%0d]: got %h want %h", i, out_instr, exp_order[i]); end
      tick();
    end
    out_ready = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL fullpop_end_valid: got %b want 0", out_valid); end
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_instr = 32'h24400000 + i; in_pc8 = 32'h00003300 + 4 * i;
      tick();
    end
    in_valid = 1'b0;
    n_checks++; if (count !== 3'd2) begin n_fail++; $display("FAIL mid_pre_count: got %0d want 2", count); end
    #2 clr = 1'b1;
    sb.delete();
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset_valid: got %b want 0", out_valid); end
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL mid_reset_count: got %0d want 0", count); end
    n_checks++; if (out_instr !== 32'h0 || out_pc8 !== 32'h0) begin n_fail++; $display("FAIL mid_reset_data: got %h/%h want 0/0", out_instr, out_pc8); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_reset_in_ready: got %b want 1", in_ready); end
    @(negedge clk);
    clr = 1'b0;
    in_valid = 1'b1; in_instr = 32'h00000020; in_pc8 = 32'h00003008;
    tick();
    in_valid = 1'b0;
    n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL mid_after_count: got %0d want 1", count); end
    n_checks++; if (out_instr !== 32'h00000020 || out_pc8 !== 32'h00003008) begin n_fail++; $display("FAIL mid_after_head: got %h/%h want 00000020/00003008", out_instr, out_pc8); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_after_alone: got valid=%b want 0", out_valid); end
  endtask

  initial begin
    clr = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc8 = '0;
    test_reset();
    test_fill_drain();
    test_streaming();
    test_flush();
    test_full_pop();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
- Instruction queue between the fetch stage and decode in the 5-stage MIPS pipeline.
- Captures {instr, pc8} pairs from fetch in a small circular FIFO and presents the oldest pair to decode.
- Decouples decode stalls from fetch: fetch is stalled only when the queue is full.
- Decode/branch logic flushes the queue on a taken redirect.

Parameters:
- DEPTH, 4, number of entries; power of two, at least 2.
- DW, 32, width of the instr and pc8 fields.

Ports:
- clk  in  1  pipeline clock; all state updates on its rising edge.
- clr  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous discard of all entries (taken branch/jump redirect).
- in_valid  in  1  fetch presents a valid instr/pc8 this cycle.
- in_instr  in  DW  instruction word from fetch.
- in_pc8  in  DW  PC+8 of that instruction, from fetch.
- in_ready  out  1  queue accepts a push; fetch stall = ~in_ready.
- out_valid  out  1  head entry is valid.
- out_instr  out  DW  head instruction; 32'h00000000 (NOP) when empty.
- out_pc8  out  DW  head pc8; 32'h00000000 when empty.
- out_ready  in  1  decode consumes the head this cycle (decode not stalled).
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.

Behaviour:
- Reset (clr=1, asynchronous, takes effect immediately without a clock edge):
  - read pointer, write pointer and count go to 0; occupancy state is cleared.
  - out_valid=0, out_instr=0, out_pc8=0, in_ready=1, count=0.
  - Storage contents are don't-care; outputs are masked to 0 while empty.
- Push = in_valid & in_ready. Pop = out_valid & out_ready.
- in_ready = (count != DEPTH). There is no push-while-full even if a pop happens the same cycle.
- out_valid = (count != 0). Head fields come combinationally from the entry at the read pointer, masked to 0 when empty.
- Latency:
  - A pushed entry becomes visible on out_* in the cycle after the push edge.
  - There is no same-cycle bypass from in_* to out_*.
- On a rising clk edge, priority is clr > flush > normal operation.
  - flush=1: pointers and count go to 0; a same-cycle push or pop is ignored; the queue is empty next cycle.
  - Push only: write the entry at the write pointer; write pointer +1; count +1.
  - Pop only: read pointer +1; count -1.
  - Push and pop together: both pointers advance; count unchanged.
    - If count==1, the popped head is the old entry and the pushed entry becomes the new head.
  - Neither: hold all state.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH (e.g. 3 -> 0 for DEPTH=4).
- Full/empty are distinguished by count, not by pointer equality.
- out_ready while empty and in_valid while full have no effect.
- Reset asserted mid-operation (including in the middle of a flush or a simultaneous push/pop) discards every entry. Operation restarts on the first clock edge after clr deasserts.
- The queue never modifies instr or pc8; decode derives PC as pc8-8.

Decomposition:
- Shared package holds:
  - the data width constant (32);
  - the NOP encoding 32'h00000000;
  - the reset PC constant 32'h00003000, so fetch and decode use one definition.
- Single module. Storage array, pointers and count are inline; no sub-module is warranted at this size.

Test Plan:
- Reset: assert clr between edges -> out_valid=0, out_instr=0, in_ready=1, count=0 with no clock edge required.
- Fill/drain, out_ready=0:
  - Push instr 0x24080001/0x24090002/0x240A0003/0x240B0004 with pc8 0x3008/0x300C/0x3010/0x3014 -> count=4, in_ready=0.
  - A fifth push is ignored.
  - Then hold out_ready=1 -> the four pairs emerge in order, followed by out_valid=0 and out_instr=0.
- Streaming, in_valid=1 and out_ready=1 every cycle from empty:
  - First cycle: out_valid=0.
  - Then one entry per cycle in order with count steady at 1.
  - Pointers wrap past DEPTH-1 with no loss or duplication over 10 instructions.
- Flush with count=3 plus a simultaneous push and pop -> next cycle count=0 and out_valid=0. The pushed entry is absent; the following push appears alone.
- Full plus pop: with count=4, in_valid=1 and out_ready=1 -> pop occurs, push is refused (in_ready=0), count=3. The refused instruction is accepted on the next cycle.
- Reset mid-stream: assert clr with count=2 -> immediate empty outputs. After release, a push of 0x00000020 with pc8 0x3008 is the only entry visible the following cycle.
